// File: rtl/fifo_pkg.sv
// fifo_pkg: shared trigger-mode encodings and width helper for the FIFO controller
package fifo_pkg;
    localparam int FIFO_MODE_LEVEL = 0;
    localparam int FIFO_MODE_EDGE = 1;
    typedef enum logic {MODE_LEVEL = 1'b0, MODE_EDGE = 1'b1} fifo_mode_e;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_req_gen.sv
// fifo_req_gen: turns a trigger into a request, either on its rising edge or on every high cycle
module fifo_req_gen
    import fifo_pkg::*;
#(
    parameter int EDGE_MODE = FIFO_MODE_EDGE
)(
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic req
);
    logic trig_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) trig_q <= 1'b0;
        else trig_q <= trig;
    assign req = (EDGE_MODE == FIFO_MODE_EDGE) ? trig & ~trig_q : trig;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller driving an external FIFO RAM
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1,
    parameter int EDGE_MODE = FIFO_MODE_EDGE,
    localparam int AW = clog2(DEPTH) < 1 ? 1 : clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig_write,
    input  logic          trig_read,
    input  logic          flush,
    input  logic          err_clr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);
    logic          wr_req, rd_req, wr_acc, rd_acc;
    logic [AW-1:0] wr_ptr, rd_ptr;

    fifo_req_gen #(.EDGE_MODE(EDGE_MODE)) u_wr_gen (
        .clk(clk), .rst_n(rst_n), .trig(trig_write), .req(wr_req)
    );
    fifo_req_gen #(.EDGE_MODE(EDGE_MODE)) u_rd_gen (
        .clk(clk), .rst_n(rst_n), .trig(trig_read), .req(rd_req)
    );

    // a full FIFO still takes a write when a read frees a slot in the same cycle
    assign wr_acc = wr_req & (~full | rd_req) & ~flush;
    assign rd_acc = rd_req & ~empty & ~flush;
    assign wr_en = wr_acc;
    assign rd_ack = rd_acc;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign almost_full = count >= CW'(AF_TH);
    assign almost_empty = count <= CW'(AE_TH);

    // explicit wrap so non-power-of-two depths work
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (wr_acc) wr_ptr <= inc(wr_ptr);
                if (rd_acc) rd_ptr <= inc(rd_ptr);
                if (wr_acc != rd_acc) count <= wr_acc ? count + CW'(1) : count - CW'(1);
            end
            overflow <= ~err_clr & (overflow | (wr_req & ~wr_acc & ~flush));
            underflow <= ~err_clr & (underflow | (rd_req & ~rd_acc & ~flush));
        end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl over a 4-deep edge, 5-deep edge and 4-deep level variant
module tb_fifo_ctrl;
  import fifo_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       a_tw = 0, a_tr = 0, a_flush = 0, a_ec = 0;
  logic       a_wr_en, a_rd_ack, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [1:0] a_wr_addr, a_rd_addr;
  logic [2:0] a_count;
  logic       b_tw = 0, b_tr = 0;
  logic       b_wr_en, b_rd_ack, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_wr_addr, b_rd_addr;
  logic [2:0] b_count;
  logic       c_tw = 0, c_tr = 0;
  logic       c_wr_en, c_rd_ack, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [1:0] c_wr_addr, c_rd_addr;
  logic [2:0] c_count;
  fifo_ctrl #(.DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .trig_write(a_tw), .trig_read(a_tr), .flush(a_flush),
    .err_clr(a_ec), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .rd_addr(a_rd_addr),
    .rd_ack(a_rd_ack), .count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf)
  );
  fifo_ctrl #(.DEPTH(5), .AF_TH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .trig_write(b_tw), .trig_read(b_tr), .flush(1'b0),
    .err_clr(1'b0), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .rd_addr(b_rd_addr),
    .rd_ack(b_rd_ack), .count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf)
  );
  fifo_ctrl #(.DEPTH(4), .EDGE_MODE(FIFO_MODE_LEVEL)) u_c (
    .clk(clk), .rst_n(rst_n), .trig_write(c_tw), .trig_read(c_tr), .flush(1'b0),
    .err_clr(1'b0), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .rd_addr(c_rd_addr),
    .rd_ack(c_rd_ack), .count(c_count), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .overflow(c_ovf), .underflow(c_unf)
  );
  int qa[$], qb[$], qc[$];
  int n_assert = 0, n_fail = 0, pa = 0, pc = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))
`define SB(t, en, addr, q) if (en) begin if (q.size() == 0) `CHK({t, "_unexpected_wr_en"}, en, 0); else `CHK({t, "_wr_addr"}, addr, q.pop_front()); end
  task automatic step();
    #2;
    if (a_wr_en) pa++;
    if (c_wr_en) pc++;
    `SB("a", a_wr_en, a_wr_addr, qa)
    `SB("b", b_wr_en, b_wr_addr, qb)
    `SB("c", c_wr_en, c_wr_addr, qc)
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_count", a_count, 0);
    `CHK("rst_empty", a_empty, 1);
    `CHK("rst_almost_empty", a_ae, 1);
    `CHK("rst_full", a_full, 0);
    `CHK("rst_almost_full", a_af, 0);
    `CHK("rst_overflow", a_ovf, 0);
    `CHK("rst_underflow", a_unf, 0);
    `CHK("rst_wr_addr", a_wr_addr, 0);
    `CHK("rst_rd_addr", a_rd_addr, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      a_tw = 1;
      if (i < 4) qa.push_back(i);
      #1;
      `CHK($sformatf("fill_wr_en_%0d", i), a_wr_en, i < 4);
      n_assert++;
      if (a_wr_en !== (i < 4)) begin
        n_fail++;
        $error("FAIL fill_wr_en_direct_%0d: observed %0b", i, a_wr_en);
      end
      step();
      a_tw = 0;
      step();
    end
    `CHK("fill_count", a_count, 4);
    `CHK("fill_full", a_full, 1);
    `CHK("fill_almost_full", a_af, 1);
    `CHK("fill_empty", a_empty, 0);
    `CHK("fill_overflow", a_ovf, 1);
    `CHK("fill_sb_drained", qa.size(), 0);
    a_tw = 1;
    a_tr = 1;
    qa.push_back(0);
    #1;
    `CHK("full_sim_wr_en", a_wr_en, 1);
    `CHK("full_sim_rd_ack", a_rd_ack, 1);
    `CHK("full_sim_rd_addr_pre", a_rd_addr, 0);
    step();
    a_tw = 0;
    a_tr = 0;
    `CHK("full_sim_count", a_count, 4);
    `CHK("full_sim_wr_addr", a_wr_addr, 1);
    `CHK("full_sim_rd_addr", a_rd_addr, 1);
    step();
    a_tr = 1;
    #1;
    `CHK("read_rd_ack", a_rd_ack, 1);
    step();
    a_tr = 0;
    `CHK("read_count", a_count, 3);
    `CHK("read_rd_addr", a_rd_addr, 2);
    step();
    a_ec = 1;
    step();
    a_ec = 0;
    `CHK("err_clr_overflow", a_ovf, 0);
    a_flush = 1;
    a_tw = 1;
    #1;
    `CHK("flush_wr_en", a_wr_en, 0);
    step();
    a_flush = 0;
    `CHK("flush_count", a_count, 0);
    `CHK("flush_wr_addr", a_wr_addr, 0);
    `CHK("flush_rd_addr", a_rd_addr, 0);
    `CHK("flush_empty", a_empty, 1);
    `CHK("flush_overflow", a_ovf, 0);
    #1;
    `CHK("flush_held_trig_wr_en", a_wr_en, 0);
    step();
    a_tw = 0;
    step();
    a_tw = 1;
    a_tr = 1;
    qa.push_back(0);
    #1;
    `CHK("empty_sim_wr_en", a_wr_en, 1);
    `CHK("empty_sim_rd_ack", a_rd_ack, 0);
    step();
    a_tw = 0;
    a_tr = 0;
    `CHK("empty_sim_count", a_count, 1);
    `CHK("empty_sim_underflow", a_unf, 1);
    `CHK("empty_sim_overflow", a_ovf, 0);
    step();
    a_tr = 1;
    step();
    a_tr = 0;
    step();
    `CHK("drain_count", a_count, 0);
    a_tr = 1;
    a_ec = 1;
    #1;
    `CHK("clr_read_rd_ack", a_rd_ack, 0);
    step();
    a_tr = 0;
    a_ec = 0;
    `CHK("clr_read_underflow", a_unf, 0);
    step();
    pa = 0;
    pc = 0;
    a_tw = 1;
    c_tw = 1;
    qa.push_back(1);
    for (int i = 0; i < 3; i++) qc.push_back(i);
    repeat (3) step();
    a_tw = 0;
    c_tw = 0;
    step();
    `CHK("edge_pulses", pa, 1);
    `CHK("level_pulses", pc, 3);
    `CHK("edge_count", a_count, 1);
    `CHK("level_count", c_count, 3);
    `CHK("level_almost_full", c_af, 1);
    `CHK("level_full", c_full, 0);
    `CHK("edge_sb_drained", qa.size(), 0);
    `CHK("level_sb_drained", qc.size(), 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 3 || i >= 6) begin
        b_tw = 1;
        qb.push_back(i < 3 ? i : (i - 3) % 5);
      end else b_tr = 1;
      #1;
      if (b_tr) begin
        `CHK($sformatf("wrap_rd_ack_%0d", i), b_rd_ack, 1);
        `CHK($sformatf("wrap_rd_addr_%0d", i), b_rd_addr, i - 3);
        n_assert++;
        if (b_rd_ack !== 1'b1 || b_rd_addr !== 3'(i - 3)) begin
          n_fail++;
          $error("FAIL wrap_read_direct_%0d: rd_ack %0b rd_addr %0d", i, b_rd_ack, b_rd_addr);
        end
      end
      step();
      b_tw = 0;
      b_tr = 0;
      step();
    end
    `CHK("wrap_rd_addr", b_rd_addr, 3);
    `CHK("wrap_wr_addr", b_wr_addr, 2);
    `CHK("wrap_count", b_count, 4);
    `CHK("wrap_almost_full", b_af, 1);
    `CHK("wrap_full", b_full, 0);
    `CHK("wrap_almost_empty", b_ae, 0);
    `CHK("wrap_sb_drained", qb.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("async_rst_a_count", a_count, 0);
    `CHK("async_rst_a_wr_addr", a_wr_addr, 0);
    `CHK("async_rst_a_empty", a_empty, 1);
    `CHK("async_rst_b_count", b_count, 0);
    `CHK("async_rst_b_rd_addr", b_rd_addr, 0);
    `CHK("async_rst_c_count", c_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
